bcd_converter_seq: RTL and testbench
====================================

Name: bcd_converter_seq

Overview:
Iterative binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm with one shift per clock. It is the parametrised, sequential successor of the combinational add-3-if-≥5 cell. Width, digit count and signed/unsigned mode are generic. It sits between arithmetic datapaths and the 7-segment/display drivers, with a start/busy/done handshake.

Parameters:
BIN_WIDTH, 8, width of the binary input (≥2).
DIGITS, 3, number of BCD output digits. Elaboration must fail unless 10^DIGITS > max magnitude: 2^BIN_WIDTH−1 when unsigned, 2^(BIN_WIDTH−1) when signed.
SIGNED_IN, 0, 0 = bin_in is unsigned; 1 = bin_in is two's complement and the magnitude is converted.

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request a conversion of bin_in; sampled only when not busy
bin_in  input  BIN_WIDTH  value to convert; sampled on the accepting edge only
busy  output  1  conversion in progress
done  output  1  one-cycle pulse; bcd_out and neg_out are valid from this cycle on
bcd_out  output  4*DIGITS  BCD result; digit 0 is in bits [3:0] (ones), digit k is in bits [4k+3:4k]
neg_out  output  1  result is negative (SIGNED_IN=1 only; tied 0 otherwise)

Behaviour:
- Reset (synchronous, priority over everything else):
  - state=IDLE; busy=0, done=0, bcd_out=0, neg_out=0; internal scratch and counter cleared.
- States: IDLE, SHIFT, DONE.
- IDLE or DONE with start=1 (accepting edge):
  - Latch the magnitude: bin_in unsigned, or |bin_in| if SIGNED_IN=1 and the MSB is 1. Use BIN_WIDTH-bit arithmetic; −2^(BIN_WIDTH−1) maps to 2^(BIN_WIDTH−1).
  - Latch the sign into the pending sign register, clear the BCD scratch, set counter=0, go to SHIFT.
- DONE with start=0: go to IDLE.
- IDLE with start=0: remain in IDLE.
- SHIFT, on each edge:
  - Every scratch digit ≥5 gets +3 (4-bit, no carry between digits). All digits are adjusted in parallel.
  - Then {scratch, magnitude} shifts left by 1; the magnitude MSB enters scratch bit 0.
  - Counter increments.
- On the BIN_WIDTH-th SHIFT edge:
  - The shifted scratch is written into bcd_out and the pending sign into neg_out.
  - Go to DONE.
- Timing, with start sampled at the end of cycle 0:
  - busy=1 in cycles 1..BIN_WIDTH.
  - done=1 and busy=0 in cycle BIN_WIDTH+1.
  - Latency is BIN_WIDTH+1 cycles; throughput is one conversion per BIN_WIDTH+1 cycles.
- done is high only while state=DONE, i.e. exactly one cycle.
- busy is high only in SHIFT.
- start while busy is ignored: no queuing, no effect on the ongoing conversion.
- Back-to-back operation: start in the DONE cycle is accepted, so busy is high again in the next cycle.
- bcd_out and neg_out hold the last result until the next conversion completes; they do not change during SHIFT.
- Reset mid-conversion aborts: no done pulse, and bcd_out returns to 0.
- Zero input yields all-zero BCD with neg_out=0.
- Negative zero cannot occur.
- Unused upper digits read 0.

Test Plan:
- Default params, bin_in=255 with a 1-cycle start -> busy in cycles 1..8; done pulse in cycle 9 only; bcd_out=12'h255, neg_out=0.
- bin_in=0, then 99, then 100 -> bcd_out=12'h000, 12'h099, 12'h100; each done is exactly one cycle.
- Start held high continuously with bin_in 37 then 200 -> done in cycles 9 and 18 with 12'h037 and 12'h200; a bin_in change during busy has no effect.
- Start at 45, reset asserted in cycle 4 -> busy=0, done never pulses, bcd_out=0; a new start at 7 then gives 12'h007 after 9 cycles.
- SIGNED_IN=1, BIN_WIDTH=8: inputs −128, −1, 127 -> bcd_out=12'h128/12'h001/12'h127, neg_out=1/1/0.
- BIN_WIDTH=16, DIGITS=5: 65535 -> bcd_out=20'h65535; done in cycle 17; 1000 -> 20'h01000.

Source files
------------

// File: rtl/bcd_converter_seq.sv
// Sequential binary-to-BCD converter (double-dabble, one shift per clock).
// Handshake: start is accepted only in IDLE/DONE; busy marks SHIFT; done pulses once.
module bcd_converter_seq #(
  parameter int BIN_WIDTH = 8,
  parameter int DIGITS    = 3,
  parameter int SIGNED_IN = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [BIN_WIDTH-1:0]   bin_in,
  output logic                   busy,
  output logic                   done,
  output logic [4*DIGITS-1:0]    bcd_out,
  output logic                   neg_out,
  output logic [1:0]             state_dbg
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(BIN_WIDTH + 1);

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int k = 0; k < n; k++) p = p * 64'd10;
    return p;
  endfunction

  localparam logic [63:0] MAX_MAG = (SIGNED_IN != 0) ? (64'd1 << (BIN_WIDTH - 1))
                                                     : ((64'd1 << BIN_WIDTH) - 64'd1);

  // Refuse to build a converter whose digits cannot hold the largest magnitude.
  if (BIN_WIDTH < 2 || pow10(DIGITS) <= MAX_MAG) begin : g_param_check
    $error("bcd_converter_seq: DIGITS too small for BIN_WIDTH/SIGNED_IN");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [BIN_WIDTH-1:0]   mag_q, mag_d;
  logic [BW-1:0]          scr_q, scr_d;
  logic                   sign_q, sign_d;
  logic [BW-1:0]          bcd_q, bcd_d;
  logic                   neg_q, neg_d;

  logic                   accept;
  logic                   last_shift;
  logic                   in_neg;
  logic [BIN_WIDTH-1:0]   in_mag;
  logic [BW-1:0]          adj;
  logic [BW-1:0]          scr_sh;
  logic [BIN_WIDTH-1:0]   mag_sh;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mag_q   <= '0;
      scr_q   <= '0;
      sign_q  <= 1'b0;
      bcd_q   <= '0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mag_q   <= mag_d;
      scr_q   <= scr_d;
      sign_q  <= sign_d;
      bcd_q   <= bcd_d;
      neg_q   <= neg_d;
    end
  end

  assign accept     = start && (state_q != S_SHIFT);
  assign last_shift = (state_q == S_SHIFT) && (cnt_q == CW'(BIN_WIDTH - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_SHIFT;
      S_SHIFT: if (last_shift) state_d = S_DONE;
      S_DONE:  state_d = start ? S_SHIFT : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: add-3 on every digit in parallel, then shift {scratch, magnitude}.
  always_comb begin
    in_neg = (SIGNED_IN != 0) && bin_in[BIN_WIDTH-1];
    in_mag = in_neg ? (~bin_in + {{(BIN_WIDTH-1){1'b0}}, 1'b1}) : bin_in;
    for (int d = 0; d < DIGITS; d++) begin
      adj[4*d +: 4] = (scr_q[4*d +: 4] >= 4'd5) ? (scr_q[4*d +: 4] + 4'd3) : scr_q[4*d +: 4];
    end
    scr_sh = {adj[BW-2:0], mag_q[BIN_WIDTH-1]};
    mag_sh = {mag_q[BIN_WIDTH-2:0], 1'b0};

    cnt_d  = cnt_q;
    mag_d  = mag_q;
    scr_d  = scr_q;
    sign_d = sign_q;
    bcd_d  = bcd_q;
    neg_d  = neg_q;
    if (accept) begin
      mag_d  = in_mag;
      sign_d = in_neg;
      scr_d  = '0;
      cnt_d  = '0;
    end else if (state_q == S_SHIFT) begin
      scr_d = scr_sh;
      mag_d = mag_sh;
      cnt_d = cnt_q + CW'(1);
      if (last_shift) begin
        bcd_d = scr_sh;
        neg_d = sign_q;
      end
    end
  end

  always_comb begin
    busy      = (state_q == S_SHIFT);
    done      = (state_q == S_DONE);
    bcd_out   = bcd_q;
    neg_out   = neg_q;
    state_dbg = state_q;
  end

endmodule

// File: tb/tb_bcd_converter_seq.sv
// Bench for bcd_converter_seq: three configurations (8-bit unsigned, 8-bit signed,
// 16-bit/5-digit) checked every cycle against an arithmetic model plus literal vectors.
module tb_bcd_converter_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_v [3];
  logic [15:0] bin_v   [3];
  logic        busy_v  [3];
  logic        done_v  [3];
  logic        neg_v   [3];
  logic [19:0] bcd_v   [3];
  logic [11:0] bcd0, bcd1;
  logic [19:0] bcd2;
  logic [1:0]  st0, st1, st2;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  bcd_converter_seq u0 (
    .clk(clk), .reset(reset), .start(start_v[0]), .bin_in(bin_v[0][7:0]),
    .busy(busy_v[0]), .done(done_v[0]), .bcd_out(bcd0), .neg_out(neg_v[0]), .state_dbg(st0)
  );
  bcd_converter_seq #(.BIN_WIDTH(8), .DIGITS(3), .SIGNED_IN(1)) u1 (
    .clk(clk), .reset(reset), .start(start_v[1]), .bin_in(bin_v[1][7:0]),
    .busy(busy_v[1]), .done(done_v[1]), .bcd_out(bcd1), .neg_out(neg_v[1]), .state_dbg(st1)
  );
  bcd_converter_seq #(.BIN_WIDTH(16), .DIGITS(5), .SIGNED_IN(0)) u2 (
    .clk(clk), .reset(reset), .start(start_v[2]), .bin_in(bin_v[2]),
    .busy(busy_v[2]), .done(done_v[2]), .bcd_out(bcd2), .neg_out(neg_v[2]), .state_dbg(st2)
  );

  assign bcd_v[0] = {8'h00, bcd0};
  assign bcd_v[1] = {8'h00, bcd1};
  assign bcd_v[2] = bcd2;

  task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d actual=%h expected=%h", name, i, act, exp);
    end
  endtask

  function automatic int wid(input int i);
    return (i == 2) ? 16 : 8;
  endfunction

  // Reference result {neg, bcd}: magnitude by plain arithmetic, digits by repeated /10.
  function automatic logic [20:0] model(input int i, input logic [15:0] v);
    int unsigned w, mag;
    logic        n;
    logic [19:0] b;
    w   = wid(i);
    mag = 32'(v) & ((32'd1 << w) - 32'd1);
    n   = 1'b0;
    if (i == 1 && mag >= (32'd1 << (w - 1))) begin
      n   = 1'b1;
      mag = (32'd1 << w) - mag;
    end
    b = '0;
    for (int k = 0; k < 5; k++) begin
      b[4*k +: 4] = 4'(mag % 10);
      mag = mag / 10;
    end
    return {n, b};
  endfunction

  // Timeline model: phase 0 idle, 1..W busy, W+1 done.
  int          phase [3] = '{0, 0, 0};
  logic [20:0] pend  [3];
  logic [20:0] outv  [3] = '{21'd0, 21'd0, 21'd0};
  logic [20:0] exp_q0[$], exp_q1[$], exp_q2[$];

  always @(posedge clk) begin
    int          w;
    logic [20:0] r;
    for (int i = 0; i < 3; i++) begin
      w = wid(i);
      if (reset) begin
        phase[i] <= 0;
        outv[i]  <= '0;
      end else if (phase[i] == 0 || phase[i] == w + 1) begin
        if (start_v[i]) begin
          r = model(i, bin_v[i]);
          phase[i] <= 1;
          pend[i]  <= r;
          case (i)
            0: exp_q0.push_back(r);
            1: exp_q1.push_back(r);
            default: exp_q2.push_back(r);
          endcase
        end else begin
          phase[i] <= 0;
        end
      end else if (phase[i] == w) begin
        phase[i] <= w + 1;
        outv[i]  <= pend[i];
      end else begin
        phase[i] <= phase[i] + 1;
      end
    end
    if (reset) begin
      exp_q0.delete();
      exp_q1.delete();
      exp_q2.delete();
    end
  end

  // Per-cycle compare plus scoreboard pop on every done pulse.
  always @(negedge clk) begin
    logic [20:0] e;
    bit          have;
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        chk("busy", i, 32'(busy_v[i]), 32'(phase[i] >= 1 && phase[i] <= wid(i)));
        chk("done", i, 32'(done_v[i]), 32'(phase[i] == wid(i) + 1));
        chk("bcd",  i, 32'(bcd_v[i]),  32'(outv[i][19:0]));
        chk("neg",  i, 32'(neg_v[i]),  32'(outv[i][20]));
        if (done_v[i]) begin
          have = 1'b0;
          e    = '0;
          case (i)
            0: if (exp_q0.size() > 0) begin e = exp_q0.pop_front(); have = 1'b1; end
            1: if (exp_q1.size() > 0) begin e = exp_q1.pop_front(); have = 1'b1; end
            default: if (exp_q2.size() > 0) begin e = exp_q2.pop_front(); have = 1'b1; end
          endcase
          chk("sb_nonempty", i, 32'(have), 32'd1);
          if (have) chk("sb_result", i, 32'({neg_v[i], bcd_v[i]}), 32'(e));
        end
      end
    end
  end

  task automatic conv(input int i, input logic [15:0] v, input logic [19:0] lit,
                      input logic litneg, input int lat);
    int n;
    @(negedge clk);
    start_v[i] = 1'b1;
    bin_v[i]   = v;
    @(negedge clk);
    start_v[i] = 1'b0;
    n = 1;
    while (!done_v[i] && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("latency", i, 32'(n), 32'(lat));
    chk("bcd_lit", i, 32'(bcd_v[i]), 32'(lit));
    chk("neg_lit", i, 32'(neg_v[i]), 32'(litneg));
    @(negedge clk);
    chk("done_one_cycle", i, 32'(done_v[i]), 32'd0);
  endtask

  initial begin
    int d1, d2, dseen;
    logic [19:0] b1, b2;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start_v[i] = 1'b0;
      bin_v[i]   = '0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("rst_busy", i, 32'(busy_v[i]), 32'd0);
      chk("rst_done", i, 32'(done_v[i]), 32'd0);
      chk("rst_bcd",  i, 32'(bcd_v[i]),  32'd0);
      chk("rst_neg",  i, 32'(neg_v[i]),  32'd0);
    end
    reset  = 1'b0;
    chk_en = 1'b1;

    conv(0, 16'd255, 20'h00255, 1'b0, 9);
    conv(0, 16'd0,   20'h00000, 1'b0, 9);
    conv(0, 16'd99,  20'h00099, 1'b0, 9);
    conv(0, 16'd100, 20'h00100, 1'b0, 9);

    // Start held high: second value is taken in the DONE cycle; bin_in change mid-run ignored.
    @(negedge clk);
    start_v[0] = 1'b1;
    bin_v[0]   = 16'd37;
    d1 = -1; d2 = -1; b1 = '0; b2 = '0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 2) bin_v[0] = 16'd200;
      if (done_v[0]) begin
        if (d1 < 0) begin d1 = c; b1 = bcd_v[0]; end
        else begin d2 = c; b2 = bcd_v[0]; end
      end
      if (c == 18) start_v[0] = 1'b0;
    end
    chk("held_done1_cycle", 0, 32'(d1), 32'd9);
    chk("held_bcd1",        0, 32'(b1), 32'h037);
    chk("held_done2_cycle", 0, 32'(d2), 32'd18);
    chk("held_bcd2",        0, 32'(b2), 32'h200);

    // Reset in cycle 4 aborts the conversion of 45.
    @(negedge clk);
    start_v[0] = 1'b1;
    bin_v[0]   = 16'd45;
    dseen = 0;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (c == 1) start_v[0] = 1'b0;
      if (done_v[0]) dseen++;
      if (c == 4) reset = 1'b1;
      if (c == 5) begin
        reset = 1'b0;
        chk("abort_busy", 0, 32'(busy_v[0]), 32'd0);
        chk("abort_bcd",  0, 32'(bcd_v[0]),  32'd0);
      end
    end
    chk("abort_no_done", 0, 32'(dseen), 32'd0);
    conv(0, 16'd7, 20'h00007, 1'b0, 9);

    conv(1, 16'h0080, 20'h00128, 1'b1, 9);
    conv(1, 16'h00FF, 20'h00001, 1'b1, 9);
    conv(1, 16'h007F, 20'h00127, 1'b0, 9);
    conv(1, 16'h0000, 20'h00000, 1'b0, 9);

    conv(2, 16'd65535, 20'h65535, 1'b0, 17);
    conv(2, 16'd1000,  20'h01000, 1'b0, 17);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
